// File: rtl/logic_engine_responder.sv
`timescale 1ns/1ps
// Purpose : responder end of the CPU logic-engine req/ack handshake; serves word
//           reads from a host-programmed result table and keeps service statistics.
// Latency : ack is registered exactly LATENCY cycles after the edge that samples logic_req.
// Backpressure: none on cfg writes (one per cycle); the CPU holds logic_req until ack,
//           and one ack is issued per request (req must be seen low before the next).
// Ports   : clk/rst (async, active-high); logic_req/logic_addr in, logic_ack/logic_data/
//           logic_err out; cfg_we/cfg_idx/cfg_wdata table writes; busy, req_count,
//           err_count status outputs.
module logic_engine_responder #(
  parameter int          DEPTH     = 16,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     logic_req,
  input  logic [31:0]              logic_addr,
  output logic                     logic_ack,
  output logic [31:0]              logic_data,
  output logic                     logic_err,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_idx,
  input  logic [31:0]              cfg_wdata,
  output logic                     busy,
  output logic [15:0]              req_count,
  output logic [15:0]              err_count
);

  localparam int          IW       = $clog2(DEPTH);
  localparam int          CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, ACK, WAIT_LOW} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0]   addr_q, addr_nxt;

  logic [31:0]   tbl [DEPTH];

  logic [31:0]   dec_addr;
  logic [31:0]   dec_off;
  logic          dec_hit;
  logic [IW-1:0] dec_idx;

  // Next-state logic. An abandoned request (req low while BUSY) takes priority
  // over the final countdown edge so a dropped request never produces an ack.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = addr_q;
    case (state)
      IDLE: begin
        if (logic_req) begin
          addr_nxt  = logic_addr;
          cnt_nxt   = CNT_LOAD;
          state_nxt = (LATENCY == 1) ? ACK : BUSY;
        end
      end
      BUSY: begin
        if (!logic_req) begin
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          state_nxt = ACK;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ACK:      state_nxt = WAIT_LOW;
      WAIT_LOW: if (!logic_req) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Address decode. With LATENCY=1 the ack edge is the sampling edge itself, so
  // the live address is decoded while IDLE; otherwise the captured one is used.
  always_comb begin
    dec_addr = (state == IDLE) ? logic_addr : addr_q;
    dec_off  = dec_addr - BASE_ADDR;
    dec_hit  = (dec_addr[1:0] == 2'b00) && (dec_addr >= BASE_ADDR) &&
               ((dec_off >> 2) < DEPTH_W);
    dec_idx  = dec_off[IW+1:2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      logic_ack  <= 1'b0;
      logic_data <= '0;
      logic_err  <= 1'b0;
      busy       <= 1'b0;
      req_count  <= '0;
      err_count  <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      addr_q    <= addr_nxt;
      logic_ack <= (state_nxt == ACK);
      busy      <= (state_nxt == BUSY) || (state_nxt == ACK);
      // ACK-entry edge: response and statistics update together; data/err then
      // hold until the next ack. The table read sees pre-write contents.
      if (state_nxt == ACK) begin
        logic_data <= dec_hit ? tbl[dec_idx] : ERR_DATA;
        logic_err  <= !dec_hit;
        if (req_count != 16'hFFFF) req_count <= req_count + 16'd1;
        if (!dec_hit && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
      end
    end
  end

  // Result table: no reset, written by the host in any state.
  always_ff @(posedge clk) begin
    if (cfg_we) tbl[cfg_idx] <= cfg_wdata;
  end

endmodule

// File: tb/tb_logic_engine_responder.sv
`timescale 1ns/1ps
// Bench for logic_engine_responder: transaction-level model plus directed vectors.
module tb_logic_engine_responder;

  localparam int          LAT  = 2;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        logic_req = 1'b0;
  logic [31:0] logic_addr = '0;
  logic        logic_ack, logic_err, busy;
  logic [31:0] logic_data;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_idx = '0;
  logic [31:0] cfg_wdata = '0;
  logic [15:0] req_count, err_count;

  logic        req4 = 1'b0;
  logic [31:0] addr4 = '0;
  logic        ack4, err4, busy4;
  logic [31:0] data4;
  logic [15:0] rc4, ec4;

  int total = 0;
  int bad   = 0;
  bit run_cmp = 1'b0;
  int acks  = 0;

  always #5 clk = ~clk;

  logic_engine_responder #(.DEPTH(16), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .logic_req(logic_req), .logic_addr(logic_addr),
    .logic_ack(logic_ack), .logic_data(logic_data), .logic_err(logic_err),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_wdata(cfg_wdata),
    .busy(busy), .req_count(req_count), .err_count(err_count));

  logic_engine_responder #(.DEPTH(16), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst), .logic_req(req4), .logic_addr(addr4),
    .logic_ack(ack4), .logic_data(data4), .logic_err(err4),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_wdata(cfg_wdata),
    .busy(busy4), .req_count(rc4), .err_count(ec4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // Tracks the open request by the cycle it was accepted; an ack is due LAT
  // cycles later if req stayed high. After an ack a new request is only
  // accepted once req has been seen low, no earlier than two cycles later.
  logic [31:0] m_mem [16];
  logic        m_ack = 1'b0, m_err = 1'b0, m_busy = 1'b0;
  logic [31:0] m_data = '0;
  logic [15:0] m_req = '0, m_errc = '0;
  logic [31:0] m_addr = '0;
  int          cyc = 0, m_start = -1, m_ack_cyc = -100;
  bit          m_armed = 1'b1;
  longint      a;
  bit          hit;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ack = 0; m_data = '0; m_err = 0; m_busy = 0;
      m_req = '0; m_errc = '0; m_start = -1; m_armed = 1;
    end else begin
      cyc++;
      m_ack = 0;
      if (m_start >= 0) begin
        if (!logic_req) m_start = -1;
        else if (cyc - m_start == LAT) begin
          a   = longint'(m_addr);
          hit = (a % 4 == 0) && (a >= longint'(BASE)) && ((a - longint'(BASE)) / 4 < 16);
          m_data = hit ? m_mem[int'((a - longint'(BASE)) / 4)] : ERRD;
          m_err  = !hit;
          if (m_req != 16'hFFFF) m_req = m_req + 1;
          if (!hit && m_errc != 16'hFFFF) m_errc = m_errc + 1;
          m_ack = 1; m_start = -1; m_armed = 0; m_ack_cyc = cyc;
        end
      end else if (!m_armed) begin
        if (!logic_req && cyc > m_ack_cyc + 1) m_armed = 1;
      end else if (logic_req) begin
        m_start = cyc;
        m_addr  = logic_addr;
      end
      m_busy = (m_start >= 0) || m_ack;
      if (cfg_we) m_mem[cfg_idx] = cfg_wdata;
    end
  end

  always @(negedge clk) begin
    if (logic_ack) acks++;
    if (run_cmp) begin
      chk("m_ack", {31'b0, logic_ack}, {31'b0, m_ack});
      chk("m_data", logic_data, m_data);
      chk("m_err", {31'b0, logic_err}, {31'b0, m_err});
      chk("m_busy", {31'b0, busy}, {31'b0, m_busy});
      chk("m_req_count", {16'b0, req_count}, {16'b0, m_req});
      chk("m_err_count", {16'b0, err_count}, {16'b0, m_errc});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic cfg_write(input int idx, input logic [31:0] d);
    cfg_we = 1; cfg_idx = 4'(idx); cfg_wdata = d;
    tick();
    cfg_we = 0;
  endtask

  task automatic do_read(input logic [31:0] ad, input int hold,
                         output logic [31:0] d, output logic e, output int n);
    n = 0;
    logic_req = 1; logic_addr = ad;
    do begin tick(); n++; end while (!logic_ack && n < 20);
    if (!logic_ack) begin
      total++; bad++;
      $display("FAIL ack_timeout: no ack for addr %h after %0d cycles", ad, n);
    end
    d = logic_data; e = logic_err;
    repeat (hold) tick();
    logic_req = 0;
    repeat (2) tick();
  endtask

  logic [31:0] d;
  logic        e;
  int          n, a0, first, cnt4;

  initial begin
    #1 rst = 1;
    repeat (2) tick();
    rst = 0;
    tick();
    run_cmp = 1;
    for (int i = 0; i < 16; i++) cfg_write(i, 32'h100 + i);
    cfg_write(3, 32'hABCD_1234);
    cfg_write(0, 32'h1);
    cfg_write(5, 32'h55);
    tick();
    chk("reset_req_count", {16'b0, req_count}, 32'd0);

    // 1: basic read, ack LAT cycles after the sampling edge
    do_read(32'h100C, 0, d, e, n);
    chk("t1_latency", n, LAT + 1);
    chk("t1_data", d, 32'hABCD_1234);
    chk("t1_err", {31'b0, e}, 32'd0);
    chk("t1_req_count", {16'b0, req_count}, 32'd1);

    // 2: misses (past window, misaligned, below base) and the last in-window word
    do_read(32'h1040, 0, d, e, n);
    chk("t2_past_data", d, ERRD);
    chk("t2_past_err", {31'b0, e}, 32'd1);
    do_read(32'h1002, 0, d, e, n);
    chk("t2_misal_data", d, ERRD);
    chk("t2_misal_err", {31'b0, e}, 32'd1);
    do_read(32'h103C, 0, d, e, n);
    chk("t2_last_data", d, 32'h10F);
    chk("t2_last_err", {31'b0, e}, 32'd0);
    do_read(32'h0FFC, 0, d, e, n);
    chk("t2_below_err", {31'b0, e}, 32'd1);
    chk("t2_req_count", {16'b0, req_count}, 32'd5);
    chk("t2_err_count", {16'b0, err_count}, 32'd3);

    // 3: request held long after ack gives a single ack
    a0 = acks;
    do_read(32'h1004, 10, d, e, n);
    chk("t3_data", d, 32'h101);
    chk("t3_one_ack", acks - a0, 1);
    do_read(32'h1008, 0, d, e, n);
    chk("t3_next_data", d, 32'h102);
    chk("t3_two_acks", acks - a0, 2);

    // 4: abort one cycle after sampling, then normal service
    a0 = acks;
    logic_req = 1; logic_addr = 32'h100C;
    tick();
    chk("t4_busy", {31'b0, busy}, 32'd1);
    logic_req = 0;
    repeat (6) tick();
    chk("t4_no_ack", acks - a0, 0);
    chk("t4_idle", {31'b0, busy}, 32'd0);
    chk("t4_req_count", {16'b0, req_count}, 32'd7);
    do_read(32'h100C, 0, d, e, n);
    chk("t4_after_data", d, 32'hABCD_1234);
    chk("t4_after_count", {16'b0, req_count}, 32'd8);

    // 4b: same on a LATENCY=4 instance
    req4 = 1; addr4 = 32'h1014;
    tick();
    chk("t4b_busy", {31'b0, busy4}, 32'd1);
    req4 = 0;
    cnt4 = 0;
    repeat (6) begin tick(); if (ack4) cnt4++; end
    chk("t4b_no_ack", cnt4, 0);
    chk("t4b_rc", {16'b0, rc4}, 32'd0);
    chk("t4b_idle", {31'b0, busy4}, 32'd0);
    req4 = 1;
    first = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (ack4 && first == 0) first = k;
      if (k == 5) chk("t4b_data", data4, 32'h55);
    end
    req4 = 0;
    chk("t4b_latency", first, 5);
    chk("t4b_rc_after", {16'b0, rc4}, 32'd1);
    chk("t4b_err", {15'b0, err4, ec4}, 32'd0);
    repeat (2) tick();

    // 5: cfg write on the ack edge returns the old value
    logic_req = 1; logic_addr = 32'h1000;
    tick();
    tick();
    cfg_we = 1; cfg_idx = 4'd0; cfg_wdata = 32'h5;
    tick();
    chk("t5_ack", {31'b0, logic_ack}, 32'd1);
    chk("t5_old_data", logic_data, 32'h1);
    cfg_we = 0; logic_req = 0;
    repeat (2) tick();
    do_read(32'h1000, 0, d, e, n);
    chk("t5_new_data", d, 32'h5);

    // 6a: reset during BUSY clears everything at once; no ack follows
    a0 = acks;
    logic_req = 1; logic_addr = 32'h100C;
    tick();
    rst = 1;
    #1;
    chk("t6_ack", {31'b0, logic_ack}, 32'd0);
    chk("t6_data", logic_data, 32'd0);
    chk("t6_err", {31'b0, logic_err}, 32'd0);
    chk("t6_busy", {31'b0, busy}, 32'd0);
    chk("t6_counts", {req_count, err_count}, 32'd0);
    repeat (2) tick();
    logic_req = 0; rst = 0;
    repeat (4) tick();
    chk("t6_no_ack", acks - a0, 0);

    // 6b: counters saturate
    force u_dut.req_count = 16'hFFFE;
    force u_dut.err_count = 16'hFFFE;
    m_req = 16'hFFFE; m_errc = 16'hFFFE;
    #1;
    release u_dut.req_count;
    release u_dut.err_count;
    tick();
    do_read(32'h1040, 0, d, e, n);
    chk("t6_sat_req1", {16'b0, req_count}, 32'hFFFF);
    chk("t6_sat_err1", {16'b0, err_count}, 32'hFFFF);
    do_read(32'h1040, 0, d, e, n);
    do_read(32'h1004, 0, d, e, n);
    chk("t6_sat_req3", {16'b0, req_count}, 32'hFFFF);
    chk("t6_sat_err3", {16'b0, err_count}, 32'hFFFF);
    chk("t6_sat_data", d, 32'h101);

    run_cmp = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
